move_unpacker: RTL and testbench

MOVE_UNPACKER -- requirements
Module: move_unpacker

---
 rtl/chess_pkg.sv | 46 ++++
 rtl/mv_slot_pick.sv | 23 ++
 rtl/move_unpacker.sv | 120 ++++++++++++
 tb/tb_move_unpacker.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chess_pkg.sv
// Shared definitions for the move-list unpacking path: word geometry,
// move field offsets, the unpacker state encoding and slot helpers.
package chess_pkg;

    localparam int MV_W        = 19;
    localparam int SLOTS       = 8;
    localparam int WORD_W      = 160;
    localparam int INVALID_BIT = 18;
    localparam int COUNT_W     = 8;

    // Move field offsets inside a 19-bit move word (each field is 3 bits)
    localparam int FIELD_W      = 3;
    localparam int TO_ROW_LSB   = 0;
    localparam int TO_COL_LSB   = 3;
    localparam int FROM_ROW_LSB = 6;
    localparam int FROM_COL_LSB = 9;

    // Slot 1 sits just below the ignored top byte; later slots step down by MV_W
    localparam int SLOT1_LSB = WORD_W - 8 - MV_W;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        LOAD,
        EMIT,
        DONE
    } unpackState_t;

    // Extract the move word for slot index idx (0 = slot 1 ... 7 = slot 8)
    function automatic logic [MV_W-1:0] getSlot(input logic [WORD_W-1:0] word,
                                                input logic [2:0]        idx);
        getSlot = word[SLOT1_LSB - MV_W * int'(idx) +: MV_W];
    endfunction

    // One bit per slot, set when that slot carries a legal move (invalid bit clear)
    function automatic logic [SLOTS-1:0] slotValidMask(input logic [WORD_W-1:0] word);
        logic [SLOTS-1:0] mask;
        mask = '0;
        for (int i = 0; i < SLOTS; i++) begin
            mask[i] = ~word[SLOT1_LSB - MV_W * i + INVALID_BIT];
        end
        return mask;
    endfunction

endpackage

// File: rtl/mv_slot_pick.sv
// Priority encoder over the pending-slot mask: lowest set bit wins, so
// moves always leave in slot order and empty slots cost no cycles.
module mv_slot_pick
    import chess_pkg::*;
(
    input  logic [SLOTS-1:0] mask,
    output logic [2:0]       idx,
    output logic             anyValid
);

    // Scan from the top down so the lowest set index is the last one written
    always_comb begin
        idx      = '0;
        anyValid = 1'b0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx      = 3'(i);
                anyValid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/move_unpacker.sv
// Reads packed move-generator words (eight 19-bit slots each) from a FIFO
// and hands the legal moves one at a time to a valid/ready consumer,
// counting accepted moves and flagging when the list is exhausted.
module move_unpacker
    import chess_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WORD_W-1:0]  fifo_out,
    input  logic               fifo_empty,
    output logic               rden,
    output logic               mv_valid,
    input  logic               mv_ready,
    output logic [MV_W-1:0]    mv_data,
    output logic [COUNT_W-1:0] mv_count,
    output logic               list_done
);

    unpackState_t      state;
    unpackState_t      nextState;
    logic [WORD_W-1:0] holdWord;
    logic [SLOTS-1:0]  slotMask;
    logic [SLOTS-1:0]  loadMask;
    logic [SLOTS-1:0]  pickBit;
    logic [SLOTS-1:0]  remaining;
    logic [2:0]        pickIdx;
    logic              pickAny;
    logic              handshake;
    logic              lastMove;

    mv_slot_pick slotPick (
        .mask     (slotMask),
        .idx      (pickIdx),
        .anyValid (pickAny)
    );

    assign loadMask  = slotValidMask(fifo_out);
    assign pickBit   = 8'b1 << pickIdx;
    assign remaining = slotMask & ~pickBit;
    assign lastMove  = (remaining == '0);

    assign mv_valid  = (state == EMIT) && pickAny;
    assign mv_data   = mv_valid ? getSlot(holdWord, pickIdx) : '0;
    assign handshake = mv_valid && mv_ready;
    assign list_done = (state == DONE);

    // State register; reset drops everything back to idle at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next state and the FIFO read strobe; only one read is ever in flight
    always_comb begin
        nextState = state;
        rden      = 1'b0;
        case (state)
            IDLE: begin
                if (start) nextState = REQ;
            end
            REQ: begin
                if (fifo_empty) begin
                    nextState = DONE;
                end else begin
                    rden      = 1'b1;
                    nextState = WAIT;
                end
            end
            WAIT: begin
                nextState = LOAD;
            end
            LOAD: begin
                nextState = (|loadMask) ? EMIT : REQ;
            end
            EMIT: begin
                if (handshake && lastMove) nextState = REQ;
            end
            DONE: begin
                if (start) nextState = REQ;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Holding word, pending-slot mask and the saturating accepted-move count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            holdWord <= '0;
            slotMask <= '0;
            mv_count <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) mv_count <= '0;
                end
                LOAD: begin
                    holdWord <= fifo_out;
                    slotMask <= loadMask;
                end
                EMIT: begin
                    if (handshake) begin
                        slotMask <= remaining;
                        if (mv_count != {COUNT_W{1'b1}}) begin
                            mv_count <= mv_count + 8'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_move_unpacker.sv
// Scoreboard bench for move_unpacker: words pushed into a FIFO model queue
// their legal moves as expectations; a negedge monitor checks every
// accepted move, the count, stall stability and FIFO read discipline.
module tb_move_unpacker;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [159:0] fifo_out = '0;
    logic         fifo_empty;
    logic         rden;
    logic         mv_valid;
    logic         mv_ready = 1'b1;
    logic [18:0]  mv_data;
    logic [7:0]   mv_count;
    logic         list_done;

    logic [159:0] fifoMem [0:255];
    int           wrPtr = 0;
    int           rdPtr = 0;
    int           readyMode = 0;

    logic [18:0]  expQ [$];
    int           modelCount = 0;
    int           testsRun = 0;
    int           testsFailed = 0;
    int           rdenCount = 0;
    int           sinceRden = 100;
    logic         prevStall = 1'b0;
    logic [18:0]  prevData = '0;

    move_unpacker dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .fifo_out   (fifo_out),
        .fifo_empty (fifo_empty),
        .rden       (rden),
        .mv_valid   (mv_valid),
        .mv_ready   (mv_ready),
        .mv_data    (mv_data),
        .mv_count   (mv_count),
        .list_done  (list_done)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    assign fifo_empty = (rdPtr == wrPtr);

    // FIFO model: registered read, data valid the cycle after rden
    always @(posedge clk) begin
        if (rden && rdPtr < wrPtr) begin
            fifo_out <= fifoMem[rdPtr[7:0]];
            rdPtr    <= rdPtr + 1;
        end
    end

    // Consumer ready pattern: 0 always ready, 1 random, 2 stalled
    always @(posedge clk) begin
        #1;
        case (readyMode)
            0:       mv_ready = 1'b1;
            1:       mv_ready = ($urandom_range(0, 3) != 0);
            default: mv_ready = 1'b0;
        endcase
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Random payload with the invalid bit of slot k cleared iff validMask[k-1] is set
    function automatic logic [159:0] makeWord(input logic [7:0] validMask);
        logic [159:0] w;
        w = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        for (int k = 1; k <= 8; k++) begin
            w[170 - 19 * k] = ~validMask[k - 1];
        end
        return w;
    endfunction

    // Reference: legal moves leave in slot order 1..8
    task automatic modelExpect(input logic [159:0] w, output int n);
        logic [18:0] slot;
        n = 0;
        for (int k = 1; k <= 8; k++) begin
            slot = w[152 - 19 * k +: 19];
            if (slot[18] == 1'b0) begin
                expQ.push_back(slot);
                n++;
            end
        end
    endtask

    task automatic fifoWrite(input logic [159:0] w);
        fifoMem[wrPtr[7:0]] = w;
        wrPtr++;
    endtask

    task automatic applyStimulus(input logic [159:0] w, output int n);
        fifoWrite(w);
        modelExpect(w, n);
    endtask

    task automatic pulseStart;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts cycles from the start edge until list_done, noting the first mv_valid
    task automatic waitDone(input int budget, output int cycles, output int firstValid);
        cycles     = 1;
        firstValid = 0;
        while (!list_done && cycles < budget) begin
            @(posedge clk);
            #1;
            cycles++;
            if (mv_valid && firstValid == 0) firstValid = cycles;
        end
        if (!list_done) checkOutput("list_done timeout", 32'(list_done), 32'd1);
    endtask

    // Monitor: scoreboard pop on handshake, count model, stall and read checks
    always @(negedge clk) begin
        if (!reset) begin
            expQ.delete();
            modelCount = 0;
            prevStall  = 1'b0;
            sinceRden  = 100;
        end else begin
            checkOutput("mv_count", 32'(mv_count), 32'(modelCount));
            if (prevStall) begin
                checkOutput("stall mv_valid", 32'(mv_valid), 32'd1);
                checkOutput("stall mv_data", 32'(mv_data), 32'(prevData));
            end
            if (rden) begin
                rdenCount++;
                checkOutput("rden while empty", 32'(fifo_empty), 32'd0);
                checkOutput("rden spacing", 32'(sinceRden >= 2), 32'd1);
                sinceRden = 0;
            end else if (sinceRden < 100) begin
                sinceRden++;
            end
            if (mv_valid && mv_ready) begin
                if (expQ.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL unexpected move: got %0h, expected none at %0t", mv_data, $time);
                end else begin
                    checkOutput("move data", 32'(mv_data), 32'(expQ.pop_front()));
                end
                if (modelCount < 255) modelCount++;
            end
            prevStall = mv_valid && !mv_ready;
            prevData  = mv_data;
            if (start) modelCount = 0;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int total;
        int cyc;
        int fv;
        int r0;
        int waitN;
        logic [18:0] d0;
        logic [7:0]  c0;
        logic [159:0] w;

        // Reset state
        #12;
        checkOutput("reset rden", 32'(rden), 32'd0);
        checkOutput("reset mv_valid", 32'(mv_valid), 32'd0);
        checkOutput("reset mv_data", 32'(mv_data), 32'd0);
        checkOutput("reset mv_count", 32'(mv_count), 32'd0);
        checkOutput("reset list_done", 32'(list_done), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);

        // Slots 1, 3 and 8 valid, consumer always ready
        readyMode = 0;
        applyStimulus(makeWord(8'h85), n);
        pulseStart;
        waitDone(100, cyc, fv);
        checkOutput("three-move latency", 32'(fv), 32'd4);
        checkOutput("three-move done cycle", 32'(cyc), 32'd8);
        checkOutput("three-move count", 32'(mv_count), 32'd3);
        checkOutput("three-move leftovers", 32'(expQ.size()), 32'd0);

        // Empty FIFO at start
        r0 = rdenCount;
        pulseStart;
        waitDone(100, cyc, fv);
        checkOutput("empty done cycle", 32'(cyc), 32'd2);
        checkOutput("empty rden pulses", 32'(rdenCount - r0), 32'd0);
        checkOutput("empty count", 32'(mv_count), 32'd0);

        // All-invalid word followed by a word with only slot 2 valid
        applyStimulus(makeWord(8'h00), n);
        applyStimulus(makeWord(8'h02), n);
        r0 = rdenCount;
        pulseStart;
        waitDone(100, cyc, fv);
        checkOutput("skip-word first valid", 32'(fv), 32'd7);
        checkOutput("skip-word rden pulses", 32'(rdenCount - r0), 32'd2);
        checkOutput("skip-word count", 32'(mv_count), 32'd1);

        // Consumer stall for 5 cycles during EMIT
        readyMode = 2;
        applyStimulus(makeWord(8'hFF), n);
        pulseStart;
        waitN = 0;
        while (!mv_valid && waitN < 20) begin
            @(posedge clk);
            #1 waitN++;
        end
        checkOutput("stall reached EMIT", 32'(mv_valid), 32'd1);
        d0 = mv_data;
        c0 = mv_count;
        r0 = rdenCount;
        repeat (5) begin
            @(negedge clk);
            checkOutput("stall hold data", 32'(mv_data), 32'(d0));
            checkOutput("stall hold count", 32'(mv_count), 32'(c0));
            checkOutput("stall no rden", 32'(rdenCount - r0), 32'd0);
        end
        readyMode = 0;
        waitDone(200, cyc, fv);
        checkOutput("stall list count", 32'(mv_count), 32'd8);

        // 28 full words with a randomly stalling consumer
        readyMode = 1;
        for (int i = 0; i < 28; i++) applyStimulus(makeWord(8'hFF), n);
        pulseStart;
        waitDone(3000, cyc, fv);
        checkOutput("224-move count", 32'(mv_count), 32'd224);
        checkOutput("224-move leftovers", 32'(expQ.size()), 32'd0);

        // 34 full words: the count must stop at 255
        readyMode = 0;
        for (int i = 0; i < 34; i++) applyStimulus(makeWord(8'hFF), n);
        pulseStart;
        waitDone(3000, cyc, fv);
        checkOutput("saturated count", 32'(mv_count), 32'd255);
        checkOutput("saturated leftovers", 32'(expQ.size()), 32'd0);

        // Random lists with random slot masks
        readyMode = 1;
        for (int t = 0; t < 6; t++) begin
            total = 0;
            for (int j = 0; j < int'($urandom_range(1, 3)); j++) begin
                applyStimulus(makeWord(8'($urandom_range(0, 255))), n);
                total += n;
            end
            pulseStart;
            waitDone(600, cyc, fv);
            checkOutput("random list count", 32'(mv_count), 32'(total));
            checkOutput("random list leftovers", 32'(expQ.size()), 32'd0);
        end

        // Reset in the middle of EMIT with slots still pending
        readyMode = 2;
        applyStimulus(makeWord(8'hFF), n);
        pulseStart;
        waitN = 0;
        while (!mv_valid && waitN < 20) begin
            @(posedge clk);
            #1 waitN++;
        end
        checkOutput("pre-reset EMIT", 32'(mv_valid), 32'd1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checkOutput("async drop mv_valid", 32'(mv_valid), 32'd0);
        checkOutput("async drop mv_data", 32'(mv_data), 32'd0);
        checkOutput("async drop mv_count", 32'(mv_count), 32'd0);
        checkOutput("async drop list_done", 32'(list_done), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        readyMode = 0;
        w = makeWord(8'h41);
        fifoWrite(w);
        r0 = rdenCount;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("idle after reset rden", 32'(rdenCount - r0), 32'd0);
        checkOutput("idle after reset list_done", 32'(list_done), 32'd0);
        checkOutput("idle after reset mv_valid", 32'(mv_valid), 32'd0);
        modelExpect(w, n);
        pulseStart;
        waitDone(100, cyc, fv);
        checkOutput("post-reset list count", 32'(mv_count), 32'd2);
        checkOutput("post-reset leftovers", 32'(expQ.size()), 32'd0);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
